// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the burst memory master.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WR,
    S_RD,
    S_CAP,
    S_DONE
  } state_t;

  typedef logic [LEN_W_DEF-1:0] beats_t;

endpackage

// File: rtl/mem_master.sv
// Burst master for a latched-address memory: one address strobe per beat,
// then a write strobe or a read strobe followed by a capture cycle.
module mem_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              mem_addr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_in_en,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_out_en,
  input  logic [DATA_W-1:0] mem_out
);

  state_t              state;
  logic                wr_burst;
  logic [ADDR_W-1:0]   cur_addr;
  logic [LEN_W-1:0]    beats;
  logic                beat_end;
  logic                last_beat;

  assign beat_end  = (state == S_WR && wr_valid) || (state == S_CAP);
  assign last_beat = (beats == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wr_burst <= 1'b0;
      cur_addr <= '0;
      beats    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          wr_burst <= req_write;
          cur_addr <= req_addr;
          beats    <= req_len;
          state    <= S_ADDR;
        end
        S_ADDR:  state <= wr_burst ? S_WR : S_RD;
        S_WR:    if (wr_valid) state <= last_beat ? S_DONE : S_ADDR;
        S_RD:    state <= S_CAP;
        S_CAP:   state <= last_beat ? S_DONE : S_ADDR;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Counter only advances when another beat follows, so it never underflows.
      if (beat_end && !last_beat) begin
        beats    <= beats - 1'b1;
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign mem_addr_en = (state == S_ADDR);
  assign mem_addr    = mem_addr_en ? cur_addr : '0;
  assign wr_ready    = (state == S_WR) && wr_valid;
  assign mem_in_en   = wr_ready;
  assign mem_in      = wr_ready ? wr_data : '0;
  assign mem_out_en  = (state == S_RD);
  assign rd_valid    = (state == S_CAP);
  // Memory floats its output outside the capture cycle; never pass it through.
  assign rd_data     = rd_valid ? mem_out : '0;

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master: vector table, stall/reset sequences,
// and a random burst stream against a memory model with a read scoreboard.
module tb_mem_master;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, done, busy;
  logic [DW-1:0] rd_data;
  logic          mem_addr_en, mem_in_en, mem_out_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_in;
  wire  [DW-1:0] mem_out;

  mem_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .busy(busy),
    .mem_addr_en(mem_addr_en), .mem_addr(mem_addr),
    .mem_in_en(mem_in_en), .mem_in(mem_in),
    .mem_out_en(mem_out_en), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: latched address, registered read data, Z when not driving.
  logic [DW-1:0] mem    [0:65535];
  logic [DW-1:0] shadow [0:65535];
  logic [AW-1:0] alat = '0;
  logic [DW-1:0] q = '0;
  logic          oe = 1'b0;
  always @(posedge clk) begin
    oe <= mem_out_en;
    if (mem_addr_en) alat <= mem_addr;
    if (mem_in_en) mem[alat] <= mem_in;
    if (mem_out_en) q <= mem[alat];
  end
  assign mem_out = oe ? q : 'z;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wq [16];
  logic mon_en = 1'b0;
  int n_addr, n_wr, n_rd, n_done, first_in, first_rd, done_cyc;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("strobe_onehot", 32'(int'(mem_addr_en) + int'(mem_in_en) + int'(mem_out_en) <= 1), 1);
      if (mem_addr_en) n_addr++;
      if (wr_ready) begin
        n_wr++;
        if (first_in < 0) first_in = cyc;
      end
      if (rd_valid) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, exp_q.pop_front());
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clr_counts();
    n_addr = 0; n_wr = 0; n_rd = 0; n_done = 0;
    first_in = -1; first_rd = -1; done_cyc = -1;
  endtask

  // Issue one burst and run it to the done pulse; acc is the cycle index of ADDR.
  task automatic burst(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l,
                       input int stall, output int acc);
    int t;
    int idx;
    logic fired;
    logic [AW-1:0] ad;
    clr_counts();
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + AW'(i);
      if (w) shadow[ad] = wq[i];
      else exp_q.push_back(shadow[ad]);
    end
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l;
    idx = 0;
    wr_data = wq[0];
    @(posedge clk); #1;
    acc = cyc;
    // Scramble request fields while busy; they must be ignored.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_len   = LW'($urandom);
    t = 0;
    while (n_done == 0 && t < 2000) begin
      wr_valid = w && (t >= stall);
      @(negedge clk);
      fired = wr_ready;
      if (w && !wr_valid && t >= 1 && n_wr == 0) begin
        chk("stall_in_en", mem_in_en, 0);
        chk("stall_busy", busy, 1);
      end
      @(posedge clk); #1;
      t++;
      if (fired && idx < 15) begin
        idx++;
        wr_data = wq[idx];
      end
    end
    wr_valid = 1'b0;
    if (t >= 2000) chk("burst_timeout", 0, 1);
  endtask

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    int            stall;
    int            lat_first;
    int            lat_done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int acc;
    logic w;
    logic [AW-1:0] a;
    logic [LW-1:0] l;

    vecs[0] = '{1'b0, 16'h0010, 4'd0, 0, 2, 3};
    vecs[1] = '{1'b1, 16'h0100, 4'd3, 0, 1, 8};
    vecs[2] = '{1'b0, 16'hFFFE, 4'd2, 0, 2, 9};
    vecs[3] = '{1'b0, 16'h0100, 4'd3, 0, 2, 12};
    vecs[4] = '{1'b1, 16'h0200, 4'd0, 6, 6, 7};
    vecs[5] = '{1'b1, 16'h0201, 4'd0, 0, 1, 2};
    vecs[6] = '{1'b0, 16'h0200, 4'd1, 0, 2, 6};

    for (int i = 0; i < 65536; i++) begin
      mem[i]    = DW'(i) ^ 16'h5A5A;
      shadow[i] = DW'(i) ^ 16'h5A5A;
    end
    mem[16'h0010]    = 16'hBEEF;
    shadow[16'h0010] = 16'hBEEF;

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_en", mem_addr_en, 0);
    chk("rst_in_en", mem_in_en, 0);
    chk("rst_out_en", mem_out_en, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_in", mem_in, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("req_ready_after_rst", req_ready, 1);
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) wq[i] = (v == 1) ? DW'(16'h1111 * (i + 1)) : DW'($urandom);
      burst(vecs[v].w, vecs[v].a, vecs[v].l, vecs[v].stall, acc);
      chk($sformatf("v%0d_n_addr", v), n_addr, int'(vecs[v].l) + 1);
      chk($sformatf("v%0d_n_wr", v), n_wr, vecs[v].w ? int'(vecs[v].l) + 1 : 0);
      chk($sformatf("v%0d_n_rd", v), n_rd, vecs[v].w ? 0 : int'(vecs[v].l) + 1);
      chk($sformatf("v%0d_n_done", v), n_done, 1);
      chk($sformatf("v%0d_lat_first", v), vecs[v].w ? first_in - acc : first_rd - acc,
          vecs[v].lat_first);
      chk($sformatf("v%0d_lat_done", v), done_cyc - acc, vecs[v].lat_done);
      @(negedge clk);
      chk($sformatf("v%0d_done_width", v), done, 0);
      chk($sformatf("v%0d_idle_ready", v), req_ready, 1);
      if (v == 1)
        for (int i = 0; i < 4; i++)
          chk($sformatf("wr_mem_%0d", i), mem[16'h0100 + i], 32'(16'h1111 * (i + 1)));
    end

    // Reset during the second beat of a 4-beat read.
    clr_counts();
    exp_q.push_back(shadow[16'h0020]);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020; req_len = 4'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int t = 0; t < 20 && n_addr < 2; t++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_reached", n_addr, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_addr_en", mem_addr_en, 0);
    chk("abort_in_en", mem_in_en, 0);
    chk("abort_out_en", mem_out_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", n_done, 0);
    chk("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    burst(1'b0, 16'h0020, 4'd1, 0, acc);
    chk("post_abort_done", n_done, 1);
    chk("post_abort_lat", done_cyc - acc, 6);

    // Random stream across the address wrap.
    for (int b = 0; b < 200; b++) begin
      w = 1'($urandom);
      a = 16'hFFF0 + AW'($urandom_range(0, 31));
      l = LW'($urandom);
      for (int i = 0; i < 16; i++) wq[i] = DW'($urandom);
      burst(w, a, l, $urandom_range(0, 3), acc);
      if (n_done != 1 || n_addr != int'(l) + 1)
        chk($sformatf("rand%0d_beats", b), n_addr, int'(l) + 1);
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 Parameter DATA_W, default 16, memory data width in bits.
REQ-003 Parameter LEN_W, default 4, burst-length field width; the maximum burst is 2^LEN_W beats.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  client request valid.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_write  in  1  1 = write burst, 0 = read burst.
REQ-009 req_addr  in  ADDR_W  burst start address.
REQ-010 req_len  in  LEN_W  burst length minus one.
REQ-011 wr_valid  in  1  client write data valid.
REQ-012 wr_data  in  DATA_W  client write data.
REQ-013 wr_ready  out  1  write beat consumed this cycle.
REQ-014 rd_valid  out  1  rd_data valid this cycle; no backpressure.
REQ-015 rd_data  out  DATA_W  read beat data.
REQ-016 done  out  1  one-cycle pulse at burst end.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 mem_addr_en / mem_addr  out  1 / ADDR_W  memory address-latch strobe and address.
REQ-019 mem_in_en / mem_in  out  1 / DATA_W  memory write strobe and data.
REQ-020 mem_out_en / mem_out  out / in  1 / DATA_W  memory read strobe and registered read data.

Function
REQ-021 States: IDLE, ADDR, WR, RD, CAP, DONE; all outputs are decoded from the state and internal registers.
REQ-022 IDLE: req_ready=1; on req_valid, latch req_write, cur_addr=req_addr and beats=req_len, then go to ADDR.
REQ-023 ADDR: mem_addr_en=1 and mem_addr=cur_addr; next state is WR if writing, otherwise RD.
REQ-024 WR: hold until wr_valid; in the wr_valid cycle, mem_in_en=1, mem_in=wr_data and wr_ready=1, then end the beat.
REQ-025 RD: mem_out_en=1; next state is CAP.
REQ-026 CAP: rd_valid=1 and rd_data=mem_out; mem_out is sampled only in CAP, because the memory drives Z otherwise; then end the beat.
REQ-027 End of beat: if beats==0, go to DONE; otherwise decrement beats, set cur_addr=cur_addr+1, and return to ADDR.
REQ-028 Address increment wraps modulo 2^ADDR_W (FFFF to 0000); the beat counter never underflows.
REQ-029 DONE: done=1 for exactly one cycle, then IDLE; req_ready=0 in DONE.
REQ-030 Latency: with acceptance at edge N, the ADDR cycle is N+1.
- Single read: rd_valid in cycle N+3, done in cycle N+4.
- Single write with wr_valid already high: mem_in_en in cycle N+2, done in cycle N+3.
REQ-031 At most one of mem_addr_en, mem_in_en and mem_out_en is high in any cycle.
REQ-032 Request fields that change while busy=1 are ignored.
REQ-033 wr_valid asserted outside WR has no effect.

Reset
REQ-034 While rst=1, the state goes to IDLE and cur_addr=0, beats=0.
- All strobes, wr_ready, rd_valid, done and busy are 0; rd_data, mem_addr and mem_in are 0.
REQ-035 Reset mid-burst aborts the burst: no strobe is asserted in the cycle after the reset edge, and no done pulse is issued.
REQ-036 req_ready=1 in the first cycle after rst deasserts.

Structure
REQ-037 Shared package mem_bus_pkg holds the state enum, ADDR_W/DATA_W defaults and the beat-count type.
REQ-038 No sub-module is required; the address/beat counter stays inline.

Verification
REQ-039 Memory at 0x0010 preloaded with 0xBEEF; read, req_addr=0x0010, len=0:
- rd_valid in cycle N+3 with rd_data=0xBEEF, done in cycle N+4, exactly one mem_addr_en.
REQ-040 Write burst, addr=0x0100, len=3, data 0x1111..0x4444, wr_valid held high:
- memory holds 0x0100..0x0103 = 0x1111..0x4444, four wr_ready pulses, then done.
REQ-041 Read burst, addr=0xFFFE, len=2:
- reads 0xFFFE, 0xFFFF, 0x0000 in order (address wrap).
REQ-042 Write with wr_valid low for 5 cycles in WR:
- state holds WR, mem_in_en=0 throughout the stall.
- Write completes on the first wr_valid cycle.
REQ-043 rst asserted during the second beat of a len=3 read:
- next cycle has all strobes 0, busy=0, req_ready=1.
- No done pulse; a new request proceeds normally.
REQ-044 Random stream of 200 bursts against the memory model:
- the one-hot strobe rule holds every cycle.
- Read-back matches a scoreboard.
